// File: rtl/sine_pkg.sv
// Shared defaults and FSM encoding for the PWM width decoder.
// Imported by the decoder top and its helpers.
package sine_pkg;

   localparam int unsigned CNT_W_DEF   = 32;
   localparam int unsigned PERIOD_DEF  = 1000;
   localparam int unsigned TOL_DEF     = 2;
   localparam int unsigned TIMEOUT_DEF = 2000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEAS  = 2'd1,
      STUCK = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Three-flop synchronizer with rise/fall detect for an async input.
// Ports: clk, rst (async high), din (async in), level (synced), rise, fall.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s3 is only the one-cycle-old copy of s2 for edge detect
   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_width_decoder.sv
// Recovers PWM high time and frame period, flags period error and stuck input.
// Ports: clk, rst, pwm_in; width, period, width_valid, period_err, stuck, locked.
module pwm_width_decoder
   import sine_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned PERIOD  = PERIOD_DEF,
   parameter int unsigned TOL     = TOL_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] period,
   output logic             width_valid,
   output logic             period_err,
   output logic             stuck,
   output logic             locked
);

   localparam int unsigned CW1 = CNT_W + 1;

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ONES  = '1;
   localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] PER_C = CNT_W'(PERIOD);
   localparam logic [CNT_W:0]   HI_LIM = CW1'(PERIOD + TOL);
   localparam logic [CNT_W:0]   PER_X  = CW1'(PERIOD);
   localparam logic [CNT_W:0]   TOL_X  = CW1'(TOL);

   logic s2;
   logic rise;
   logic fall_unused;

   pwm_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (pwm_in),
      .level (s2),
      .rise  (rise),
      .fall  (fall_unused)
   );

   state_t           state;
   logic [CNT_W-1:0] tot_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W:0]   tot_x;
   logic             out_of_tol;

   // One extra bit so PERIOD+TOL and tot+TOL never wrap
   assign tot_x      = {1'b0, tot_cnt};
   assign out_of_tol = (tot_x > HI_LIM) || ((tot_x + TOL_X) < PER_X);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tot_cnt     <= '0;
         hi_cnt      <= '0;
         width       <= '0;
         period      <= '0;
         width_valid <= 1'b0;
         period_err  <= 1'b0;
         stuck       <= 1'b0;
         locked      <= 1'b0;
      end else begin
         width_valid <= 1'b0;

         // The rise cycle itself is the first cycle of the new frame
         if (rise) begin
            tot_cnt <= ONE;
            hi_cnt  <= ONE;
         end else begin
            if (tot_cnt != ONES)
               tot_cnt <= tot_cnt + ONE;
            if (s2 && (hi_cnt != ONES))
               hi_cnt <= hi_cnt + ONE;
         end

         unique case (state)
            IDLE: begin
               if (rise)
                  state <= MEAS;
            end
            MEAS: begin
               // A rise coinciding with the timeout wins
               if (rise) begin
                  width       <= hi_cnt;
                  period      <= tot_cnt;
                  period_err  <= out_of_tol;
                  width_valid <= 1'b1;
                  locked      <= 1'b1;
               end else if (tot_cnt >= TO_C) begin
                  state       <= STUCK;
                  stuck       <= 1'b1;
                  locked      <= 1'b0;
                  period      <= '0;
                  width       <= s2 ? PER_C : '0;
                  width_valid <= 1'b1;
               end
            end
            STUCK: begin
               // Recovery rise opens a partial frame, no strobe yet
               if (rise) begin
                  state <= MEAS;
                  stuck <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_width_decoder.sv
// Directed bench for pwm_width_decoder.
// Frames are driven on the falling clock edge; strobes are captured by a monitor.
module tb_pwm_width_decoder;

   logic        clk;
   logic        rst;
   logic        pwm_in;
   logic [31:0] width;
   logic [31:0] period;
   logic        width_valid;
   logic        period_err;
   logic        stuck;
   logic        locked;

   pwm_width_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .width       (width),
      .period      (period),
      .width_valid (width_valid),
      .period_err  (period_err),
      .stuck       (stuck),
      .locked      (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   int          strobes = 0;
   int          dbl = 0;
   logic        prev_v = 1'b0;
   logic [31:0] lw = '0;
   logic [31:0] lp = '0;
   logic        le = 1'b0;

   always @(negedge clk) begin
      if (width_valid) begin
         strobes = strobes + 1;
         lw = width;
         lp = period;
         le = period_err;
         if (prev_v)
            dbl = dbl + 1;
      end
      prev_v = width_valid;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame(input int hi, input int per);
      pwm_in = (hi > 0);
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (per - hi) @(negedge clk);
      #1;
   endtask

   task automatic hold(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int s0;

   initial begin
      rst = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_width", width, 0);
      chk("rst_period", period, 0);
      chk("rst_valid", width_valid, 0);
      chk("rst_err", period_err, 0);
      chk("rst_stuck", stuck, 0);
      chk("rst_locked", locked, 0);
      rst = 1'b0;
      hold(1'b0, 5);

      // nominal frames
      frame(250, 1000);
      chk("t1_lock0", locked, 0);
      chk("t1_nostrobe", strobes, 0);
      frame(250, 1000);
      chk("t1_lock1", locked, 1);
      chk("t1_strobe1", strobes, 1);
      chk("t1_w1", lw, 250);
      chk("t1_p1", lp, 1000);
      repeat (3) frame(250, 1000);
      chk("t1_strobes", strobes, 4);
      chk("t1_w", lw, 250);
      chk("t1_p", lp, 1000);
      chk("t1_err", le, 0);

      // width change at a boundary
      frame(600, 1000);
      chk("t2_old_w", lw, 250);
      chk("t2_cnt5", strobes, 5);
      frame(600, 1000);
      chk("t2_new_w", lw, 600);
      chk("t2_cnt6", strobes, 6);

      // period tolerance edges
      frame(100, 1003);
      frame(100, 1003);
      chk("t3_w", lw, 100);
      chk("t3_p1003", lp, 1003);
      chk("t3_err1", le, 1);
      frame(100, 1002);
      frame(100, 1002);
      chk("t3_p1002", lp, 1002);
      chk("t3_err0", le, 0);
      chk("t3_cnt", strobes, 10);

      // stuck low, then recovery
      s0 = strobes;
      hold(1'b0, 2100);
      chk("t4_stuck_lo", stuck, 1);
      chk("t4_w0", width, 0);
      chk("t4_p0", period, 0);
      chk("t4_unlock", locked, 0);
      chk("t4_one_strobe", strobes - s0, 1);
      frame(300, 1000);
      chk("t4_unstuck", stuck, 0);
      chk("t4_no_strobe", strobes - s0, 1);
      frame(300, 1000);
      chk("t4_rec_strobe", strobes - s0, 2);
      chk("t4_rec_w", lw, 300);
      chk("t4_rec_p", lp, 1000);
      chk("t4_relock", locked, 1);

      // stuck high
      hold(1'b1, 2100);
      chk("t4_stuck_hi", stuck, 1);
      chk("t4_w1000", width, 1000);
      chk("t4_p0_hi", period, 0);
      chk("t4_unlock_hi", locked, 0);
      hold(1'b0, 5);
      frame(300, 1000);
      chk("t4_unstuck_hi", stuck, 0);
      frame(300, 1000);
      chk("t4_rec_w_hi", lw, 300);

      // async reset in the high phase
      pwm_in = 1'b1;
      repeat (100) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_width", width, 0);
      chk("t5_period", period, 0);
      chk("t5_locked", locked, 0);
      chk("t5_stuck", stuck, 0);
      chk("t5_valid", width_valid, 0);
      chk("t5_err", period_err, 0);
      @(negedge clk);
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 5);
      s0 = strobes;
      frame(200, 1000);
      chk("t5_no_strobe", strobes - s0, 0);
      chk("t5_lock0", locked, 0);
      frame(200, 1000);
      chk("t5_strobe", strobes - s0, 1);
      chk("t5_w", lw, 200);
      chk("t5_lock1", locked, 1);

      // width sweep
      for (int w = 50; w <= 950; w += 50) begin
         frame(w, 1000);
         if (w >= 100)
            chk("t6_sweep", lw, 64'(w - 50));
      end
      frame(50, 1000);
      chk("t6_w950", lw, 950);
      hold(1'b0, 2100);
      chk("t6_w0_stuck", stuck, 1);
      chk("t6_w0", width, 0);
      hold(1'b1, 2100);
      chk("t6_w1000_stuck", stuck, 1);
      chk("t6_w1000", width, 1000);
      hold(1'b0, 5);

      chk("no_double_strobe", dbl, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
